// File: rtl/mipi_csi2_pkg.sv
// Shared definitions for the two-lane CSI-2 transmitter: data types, state
// encoding, PPI timing constants and the packet-header ECC function.
// Latency: n/a (package).  Backpressure: n/a (package).
package mipi_csi2_pkg;

  // CSI-2 data type codes
  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_LS    = 6'h02;
  localparam logic [5:0] DT_LE    = 6'h03;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  // Clock-lane lead, clock-lane trail and data-lane trail, in byte clocks
  localparam int CLK_LEAD  = 8;
  localparam int CLK_TRAIL = 8;
  localparam int HS_TRAIL  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLK_REQ,
    ST_REQ,
    ST_HDR,
    ST_PAY,
    ST_CRC,
    ST_TRAIL,
    ST_CLK_TAIL
  } state_t;

  // CSI-2 packet-header ECC: 6 Hamming parity bits over {B2,B1,B0}, top two bits zero
  function automatic logic [7:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

endpackage

// File: rtl/mipi_csi2_crc16_2b.sv
// Payload CRC-16 (reflected poly 0x8408, seed 0xFFFF), two bytes per cycle, [7:0] first.
// Latency: crc_o reflects data_i one cycle after en_i.  Backpressure: none, caller gates en_i.
// Ports: clk_i, rst_i (sync, high), clr_i (reseed), en_i (absorb data_i), data_i[15:0], crc_o[15:0].
module mipi_csi2_crc16_2b
  import mipi_csi2_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [15:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  // LSB-first shift of one byte through the reflected register
  function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = {1'b0, c[15:1]};
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_q <= 16'hFFFF;
    end else if (en_i) begin
      crc_q <= crc_byte(crc_byte(crc_q, data_i[7:0]), data_i[15:8]);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mipi_csi2_tx_lane2.sv
// Two-lane CSI-2 packet transmitter onto the PPI HS-TX interface (header+ECC, payload, CRC16).
// Latency: first lane byte CLK_LEAD+1 cycles after command accept (1 with continuous clock).
// Backpressure: beats advance only on dl_txreadyhs; s_ready follows it on payload fetches.
// Ports: core_clk/core_rst; s_cmd_{vc,dt,wc,short,valid,ready} packet command;
//   s_data/s_valid/s_ready 16-bit payload; cl/dl0/dl1_txrequesths, dl_txreadyhs, dl0/dl1_txdatahs PPI;
//   err_wc, err_underrun single-cycle error pulses; busy.
// Build option: MIPI_CSI2_TX_CONT_CLK_EN keeps the clock lane in HS permanently.
module mipi_csi2_tx_lane2
  import mipi_csi2_pkg::*;
(
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic [1:0]  s_cmd_vc,
  input  logic [5:0]  s_cmd_dt,
  input  logic [15:0] s_cmd_wc,
  input  logic        s_cmd_short,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        cl_txrequesths,
  output logic        dl0_txrequesths,
  output logic        dl1_txrequesths,
  input  logic        dl_txreadyhs,
  output logic [7:0]  dl0_txdatahs,
  output logic [7:0]  dl1_txdatahs,
  output logic        err_wc,
  output logic        err_underrun,
  output logic        busy
);

  state_t      state_q;
  logic [1:0]  vc_q;
  logic [5:0]  dt_q;
  logic [15:0] wc_q;
  logic        short_q;
  logic [3:0]  cnt_q;
  logic [14:0] pay_left_q;
  logic        cl_req_q, dl_req_q, cmd_rdy_q, busy_q, err_wc_q, err_under_q;
  logic [7:0]  lane0_q, lane1_q;

  logic [15:0] crc;
  logic [14:0] n_beats;
  logic [7:0]  di;
  logic [15:0] pay_word;
  logic        fetch;
  logic        cmd_acc;

  assign n_beats  = wc_q[15:1];
  assign di       = {vc_q, dt_q};
  // A missing payload word is replaced by zero and still counted and CRC'd
  assign pay_word = s_valid ? s_data : 16'h0000;

  // Fetch the next payload word on the beat that advances into it, so the lane
  // registers always hold the beat currently offered to the PHY.
  assign fetch = !core_rst && dl_txreadyhs &&
                 ((state_q == ST_HDR && !short_q && n_beats != 15'd0) ||
                  (state_q == ST_PAY && pay_left_q != 15'd0));

  assign cmd_acc = (state_q == ST_IDLE) && s_cmd_valid && !(!s_cmd_short && s_cmd_wc[0]);

  mipi_csi2_crc16_2b u_crc (
    .clk_i  (core_clk),
    .rst_i  (core_rst),
    .clr_i  (cmd_acc),
    .en_i   (fetch),
    .data_i (pay_word),
    .crc_o  (crc)
  );

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q     <= ST_IDLE;
      vc_q        <= 2'd0;
      dt_q        <= 6'd0;
      wc_q        <= 16'd0;
      short_q     <= 1'b0;
      cnt_q       <= 4'd0;
      pay_left_q  <= 15'd0;
      cl_req_q    <= 1'b0;
      dl_req_q    <= 1'b0;
      cmd_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_wc_q    <= 1'b0;
      err_under_q <= 1'b0;
      lane0_q     <= 8'd0;
      lane1_q     <= 8'd0;
    end else begin
      err_wc_q    <= 1'b0;
      err_under_q <= 1'b0;
`ifdef MIPI_CSI2_TX_CONT_CLK_EN
      cl_req_q    <= 1'b1;
`endif
      case (state_q)
        ST_IDLE: begin
          cmd_rdy_q <= 1'b1;
          busy_q    <= 1'b0;
          if (s_cmd_valid) begin
            if (!s_cmd_short && s_cmd_wc[0]) begin
              err_wc_q <= 1'b1;
            end else begin
              vc_q      <= s_cmd_vc;
              dt_q      <= s_cmd_dt;
              wc_q      <= s_cmd_wc;
              short_q   <= s_cmd_short;
              cmd_rdy_q <= 1'b0;
              busy_q    <= 1'b1;
`ifdef MIPI_CSI2_TX_CONT_CLK_EN
              state_q   <= ST_REQ;
              dl_req_q  <= 1'b1;
              lane0_q   <= {s_cmd_vc, s_cmd_dt};
              lane1_q   <= s_cmd_wc[7:0];
`else
              state_q   <= ST_CLK_REQ;
              cl_req_q  <= 1'b1;
              cnt_q     <= 4'(CLK_LEAD - 1);
`endif
            end
          end
        end
`ifndef MIPI_CSI2_TX_CONT_CLK_EN
        ST_CLK_REQ: begin
          if (cnt_q == 4'd0) begin
            state_q  <= ST_REQ;
            dl_req_q <= 1'b1;
            lane0_q  <= di;
            lane1_q  <= wc_q[7:0];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        // REQ carries header beat 0, HDR carries header beat 1
        ST_REQ: begin
          if (dl_txreadyhs) begin
            state_q <= ST_HDR;
            lane0_q <= wc_q[15:8];
            lane1_q <= ecc6({wc_q, di});
          end
        end
        ST_HDR: begin
          if (dl_txreadyhs) begin
            if (short_q) begin
              state_q  <= ST_TRAIL;
              dl_req_q <= 1'b0;
              lane0_q  <= 8'd0;
              lane1_q  <= 8'd0;
              cnt_q    <= 4'(HS_TRAIL - 1);
            end else if (n_beats == 15'd0) begin
              state_q <= ST_CRC;
              lane0_q <= crc[7:0];
              lane1_q <= crc[15:8];
            end else begin
              state_q     <= ST_PAY;
              lane0_q     <= pay_word[7:0];
              lane1_q     <= pay_word[15:8];
              err_under_q <= !s_valid;
              pay_left_q  <= n_beats - 15'd1;
            end
          end
        end
        ST_PAY: begin
          if (dl_txreadyhs) begin
            if (pay_left_q != 15'd0) begin
              lane0_q     <= pay_word[7:0];
              lane1_q     <= pay_word[15:8];
              err_under_q <= !s_valid;
              pay_left_q  <= pay_left_q - 15'd1;
            end else begin
              // The last word was absorbed on the previous advance, so crc is final here
              state_q <= ST_CRC;
              lane0_q <= crc[7:0];
              lane1_q <= crc[15:8];
            end
          end
        end
        ST_CRC: begin
          if (dl_txreadyhs) begin
            state_q  <= ST_TRAIL;
            dl_req_q <= 1'b0;
            lane0_q  <= 8'd0;
            lane1_q  <= 8'd0;
            cnt_q    <= 4'(HS_TRAIL - 1);
          end
        end
        ST_TRAIL: begin
          if (cnt_q == 4'd0) begin
`ifdef MIPI_CSI2_TX_CONT_CLK_EN
            state_q   <= ST_IDLE;
            cmd_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
`else
            state_q   <= ST_CLK_TAIL;
            cnt_q     <= 4'(CLK_TRAIL - 1);
`endif
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`ifndef MIPI_CSI2_TX_CONT_CLK_EN
        ST_CLK_TAIL: begin
          if (cnt_q == 4'd0) begin
            state_q   <= ST_IDLE;
            cl_req_q  <= 1'b0;
            cmd_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_cmd_ready     = cmd_rdy_q;
  assign s_ready         = fetch;
  assign cl_txrequesths  = cl_req_q;
  assign dl0_txrequesths = dl_req_q;
  assign dl1_txrequesths = dl_req_q;
  assign dl0_txdatahs    = lane0_q;
  assign dl1_txdatahs    = lane1_q;
  assign err_wc          = err_wc_q;
  assign err_underrun    = err_under_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mipi_csi2_tx_lane2.sv
module tb_mipi_csi2_tx_lane2;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b1;
  logic [1:0]  s_cmd_vc = '0;
  logic [5:0]  s_cmd_dt = '0;
  logic [15:0] s_cmd_wc = '0;
  logic        s_cmd_short = 1'b0;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        cl_txrequesths, dl0_txrequesths, dl1_txrequesths;
  logic        dl_txreadyhs = 1'b1;
  logic [7:0]  dl0_txdatahs, dl1_txdatahs;
  logic        err_wc, err_underrun, busy;

`ifdef MIPI_CSI2_TX_CONT_CLK_EN
  localparam logic CL_IDLE = 1'b1;
`else
  localparam logic CL_IDLE = 1'b0;
`endif

  mipi_csi2_tx_lane2 dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .s_cmd_vc(s_cmd_vc), .s_cmd_dt(s_cmd_dt), .s_cmd_wc(s_cmd_wc),
    .s_cmd_short(s_cmd_short), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cl_txrequesths(cl_txrequesths), .dl0_txrequesths(dl0_txrequesths),
    .dl1_txrequesths(dl1_txrequesths), .dl_txreadyhs(dl_txreadyhs),
    .dl0_txdatahs(dl0_txdatahs), .dl1_txdatahs(dl1_txdatahs),
    .err_wc(err_wc), .err_underrun(err_underrun), .busy(busy)
  );

  always #5 core_clk = ~core_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge core_clk) cyc <= cyc + 1;

  logic [15:0] exp_q[$];
  logic [15:0] src_q[$];
  bit          mon_en = 1'b0;
  int          acked_beats = 0, underrun_cnt = 0;
  logic [15:0] last_beat = '0, mon_exp, held = '0;
  bit          hold_pending = 1'b0;
  logic        cl_prev = 1'b0, dl_prev = 1'b0;
  int          cl_rise = 0, dl_rise = 0;

  // Reference ECC: each parity bit is the XOR of header bits selected by a mask
  function automatic logic [7:0] m_ecc(input logic [23:0] d);
    logic [7:0] e;
    e = 8'h00;
    e[0] = ^(d & 24'hF12CB7);
    e[1] = ^(d & 24'hF2555B);
    e[2] = ^(d & 24'h749A6D);
    e[3] = ^(d & 24'hB8E38E);
    e[4] = ^(d & 24'hDF03F0);
    e[5] = ^(d & 24'hEFFC00);
    return e;
  endfunction

  function automatic logic [15:0] m_crc(input logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) begin
      c = c ^ {8'h00, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  // Lane monitor: pops one expected beat per acknowledged beat
  always @(negedge core_clk) begin
    if (mon_en) begin
      if (hold_pending) begin
        n_tests++;
        if ({dl1_txdatahs, dl0_txdatahs} !== held) begin
          n_fail++;
          $display("FAIL hold: lanes %h, required %h", {dl1_txdatahs, dl0_txdatahs}, held);
        end
      end
      hold_pending = dl0_txrequesths && !dl_txreadyhs;
      held = {dl1_txdatahs, dl0_txdatahs};
      if (dl0_txrequesths && dl_txreadyhs) begin
        acked_beats++;
        last_beat = {dl1_txdatahs, dl0_txdatahs};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: lanes %h, required none", last_beat);
        end else begin
          mon_exp = exp_q.pop_front();
          if (last_beat !== mon_exp) begin
            n_fail++;
            $display("FAIL beat: lane1/lane0 %h, required %h", last_beat, mon_exp);
          end
        end
        n_tests++;
        if (dl1_txrequesths !== 1'b1) begin
          n_fail++;
          $display("FAIL dl1_req: %b, required 1", dl1_txrequesths);
        end
      end
      if (err_underrun) begin
        underrun_cnt++;
        n_tests++;
        if ({dl1_txdatahs, dl0_txdatahs} !== 16'h0000) begin
          n_fail++;
          $display("FAIL underrun_data: %h, required 0000", {dl1_txdatahs, dl0_txdatahs});
        end
      end
      if (cl_txrequesths && !cl_prev) cl_rise = cyc;
      if (dl0_txrequesths && !dl_prev) dl_rise = cyc;
    end else begin
      hold_pending = 1'b0;
    end
    cl_prev = cl_txrequesths;
    dl_prev = dl0_txrequesths;
  end

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic wait_accept(output bit ok);
    int budget;
    ok = 1'b0;
    budget = 0;
    while (!ok && budget < 50) begin
      @(negedge core_clk);
      if (s_cmd_ready) ok = 1'b1;
      tick();
      budget++;
    end
  endtask

  task automatic run_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                            input logic sh, input bit toggle, input int drop, input string name);
    logic [7:0]  bytes[$];
    logic [15:0] w;
    int nb, j, nexp, exp_under, fetch_cnt, src_idx, budget;
    bit ok, seen, done;
    exp_q.push_back({wc[7:0], vc, dt});
    exp_q.push_back({m_ecc({wc, vc, dt}), wc[15:8]});
    nexp = 2;
    exp_under = 0;
    if (!sh) begin
      nb = int'(wc[15:1]);
      j = 0;
      for (int k = 0; k < nb; k++) begin
        if (k == drop) begin
          w = 16'h0000;
          exp_under++;
        end else begin
          w = src_q[j];
          j++;
        end
        exp_q.push_back(w);
        bytes.push_back(w[7:0]);
        bytes.push_back(w[15:8]);
      end
      exp_q.push_back(m_crc(bytes));
      nexp += nb + 1;
    end
    acked_beats = 0; underrun_cnt = 0; cl_rise = 0; dl_rise = 0;
    tick();
    s_cmd_vc = vc; s_cmd_dt = dt; s_cmd_wc = wc; s_cmd_short = sh; s_cmd_valid = 1'b1;
    wait_accept(ok);
    s_cmd_valid = 1'b0;
    // Scramble the command bus: the latched copy must be used
    s_cmd_vc = ~vc; s_cmd_dt = ~dt; s_cmd_wc = ~wc; s_cmd_short = ~sh;
    fetch_cnt = 0; src_idx = 0; seen = 1'b0; done = 1'b0; budget = 0;
    while (ok && !done && budget < 4000) begin
      dl_txreadyhs = toggle ? ~dl_txreadyhs : 1'b1;
      s_valid = (fetch_cnt != drop) && (src_idx < src_q.size());
      s_data  = (src_idx < src_q.size()) ? src_q[src_idx] : 16'h0000;
      @(negedge core_clk);
      if (s_ready) begin
        fetch_cnt++;
        if (s_valid) src_idx++;
      end
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
      tick();
      budget++;
    end
    s_valid = 1'b0;
    dl_txreadyhs = 1'b1;
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_complete: accepted=%0b finished=0, required 1", name, ok);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing: %0d beats left, required 0", name, exp_q.size());
    end
    n_tests++;
    if (acked_beats != nexp) begin
      n_fail++;
      $display("FAIL %s_beats: %0d, required %0d", name, acked_beats, nexp);
    end
    n_tests++;
    if (underrun_cnt != exp_under) begin
      n_fail++;
      $display("FAIL %s_underrun: %0d, required %0d", name, underrun_cnt, exp_under);
    end
    n_tests++;
    if (fetch_cnt != (sh ? 0 : int'(wc[15:1]))) begin
      n_fail++;
      $display("FAIL %s_fetches: %0d, required %0d", name, fetch_cnt, sh ? 0 : int'(wc[15:1]));
    end
`ifndef MIPI_CSI2_TX_CONT_CLK_EN
    n_tests++;
    if (dl_rise - cl_rise != 8) begin
      n_fail++;
      $display("FAIL %s_clk_lead: %0d, required 8", name, dl_rise - cl_rise);
    end
`endif
    n_tests++;
    if ({cl_txrequesths, s_cmd_ready, busy} !== {CL_IDLE, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_idle: cl/rdy/busy %b, required %b", name,
               {cl_txrequesths, s_cmd_ready, busy}, {CL_IDLE, 1'b1, 1'b0});
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    core_rst = 1'b1;
    repeat (3) tick();
    @(negedge core_clk);
    n_tests++;
    if ({s_cmd_ready, s_ready, cl_txrequesths, dl0_txrequesths, dl1_txrequesths, dl0_txdatahs,
         dl1_txdatahs, err_wc, err_underrun, busy} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b srdy=%b cl=%b dl=%b%b d=%h%h errs=%b%b busy=%b, required all 0",
               s_cmd_ready, s_ready, cl_txrequesths, dl0_txrequesths, dl1_txrequesths,
               dl1_txdatahs, dl0_txdatahs, err_wc, err_underrun, busy);
    end
    tick();
    core_rst = 1'b0;
    tick();
    tick();
    @(negedge core_clk);
    n_tests++;
    if ({s_cmd_ready, busy, cl_txrequesths, dl0_txrequesths} !== {1'b1, 1'b0, CL_IDLE, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_idle: rdy/busy/cl/dl %b, required %b",
               {s_cmd_ready, busy, cl_txrequesths, dl0_txrequesths}, {1'b1, 1'b0, CL_IDLE, 1'b0});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_short_fs();
    src_q.delete();
    run_packet(2'd0, 6'h00, 16'h0000, 1'b1, 1'b0, -1, "short_fs");
  endtask

  task automatic test_long_raw8();
    logic [7:0] pb[24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                           8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                           8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    src_q.delete();
    for (int k = 0; k < 12; k++) src_q.push_back({pb[2*k+1], pb[2*k]});
    run_packet(2'd0, 6'h2A, 16'd24, 1'b0, 1'b0, -1, "long_raw8");
    n_tests++;
    if (last_beat !== 16'h00F0) begin
      n_fail++;
      $display("FAIL raw8_crc: lane1/lane0 %h, required 00f0", last_beat);
    end
  endtask

  task automatic test_long_wc0();
    src_q.delete();
    run_packet(2'd2, 6'h2A, 16'd0, 1'b0, 1'b0, -1, "long_wc0");
    n_tests++;
    if (last_beat !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wc0_crc: %h, required ffff", last_beat);
    end
  endtask

  task automatic test_odd_wc();
    int n_err, n_req, n_nrdy;
    n_err = 0; n_req = 0; n_nrdy = 0;
    tick();
    s_cmd_vc = 2'd1; s_cmd_dt = 6'h2A; s_cmd_wc = 16'd5; s_cmd_short = 1'b0; s_cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge core_clk);
      if (err_wc) n_err++;
      if (dl0_txrequesths || dl1_txrequesths || busy || cl_txrequesths !== CL_IDLE) n_req++;
      if (!s_cmd_ready) n_nrdy++;
      tick();
      if (i == 0) s_cmd_valid = 1'b0;
    end
    n_tests++;
    if (n_err != 1) begin
      n_fail++;
      $display("FAIL odd_wc_pulse: %0d pulses, required 1", n_err);
    end
    n_tests++;
    if (n_req != 0) begin
      n_fail++;
      $display("FAIL odd_wc_requests: %0d cycles with activity, required 0", n_req);
    end
    n_tests++;
    if (n_nrdy != 0) begin
      n_fail++;
      $display("FAIL odd_wc_ready: %0d cycles not ready, required 0", n_nrdy);
    end
  endtask

  task automatic test_backpressure_underrun();
    src_q.delete();
    for (int k = 0; k < 8; k++) src_q.push_back(16'($urandom));
    run_packet(2'd3, 6'h2B, 16'd16, 1'b0, 1'b1, 3, "bp_underrun");
  endtask

  task automatic test_reset_mid();
    int fetch_cnt, budget;
    bit ok;
    mon_en = 1'b0;
    src_q.delete();
    for (int k = 0; k < 8; k++) src_q.push_back(16'($urandom));
    tick();
    s_cmd_vc = 2'd0; s_cmd_dt = 6'h2B; s_cmd_wc = 16'd16; s_cmd_short = 1'b0; s_cmd_valid = 1'b1;
    wait_accept(ok);
    s_cmd_valid = 1'b0;
    fetch_cnt = 0; budget = 0;
    while (ok && fetch_cnt < 3 && budget < 200) begin
      dl_txreadyhs = 1'b1;
      s_valid = 1'b1;
      s_data = src_q[fetch_cnt];
      @(negedge core_clk);
      if (s_ready) fetch_cnt++;
      tick();
      budget++;
    end
    n_tests++;
    if (fetch_cnt != 3) begin
      n_fail++;
      $display("FAIL rst_mid_reach: %0d fetches, required 3", fetch_cnt);
    end
    core_rst = 1'b1;
    s_valid = 1'b0;
    tick();
    @(negedge core_clk);
    n_tests++;
    if ({cl_txrequesths, dl0_txrequesths, dl1_txrequesths, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid_drop: cl/dl0/dl1/busy %b, required 0000",
               {cl_txrequesths, dl0_txrequesths, dl1_txrequesths, busy});
    end
    tick();
    core_rst = 1'b0;
    exp_q.delete();
    tick();
    tick();
    mon_en = 1'b1;
    src_q.delete();
    run_packet(2'd1, 6'h00, 16'h1234, 1'b1, 1'b0, -1, "post_rst_fs");
  endtask

  initial begin
    test_reset();
    test_short_fs();
    test_long_raw8();
    test_long_wc0();
    test_odd_wc();
    test_backpressure_underrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
